main_experiment2: RTL and testbench
===================================

Name: main_experiment2

Overview:
- Single-cycle R-type execution slice: 32x32 register file, combinational R-type ALU, and writeback of the ALU result to rd.
- Adds an external debug write port (WR/WD/RW) used by benches and the bring-up harness to preload registers.
- Sits in the single-cycle CPU as the register-file + ALU datapath core, driven by the instruction word from fetch.

Parameters:
- None. Register count (32), data width (32) and register-address width (5) are fixed.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
Ins  input  32  instruction word, MIPS layout: opcode[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0]
WR  input  5  external write register address
WD  input  32  external write data
RW  input  1  external write enable
rd1  output  32  register[rs], combinational read
rd2  output  32  register[rt], combinational read
alu_result  output  32  ALU result for the current Ins
zero  output  1  1 when alu_result == 0
ovf  output  1  signed overflow flag (see Optional Feature)

Behaviour:
- Reset: rst_n low asynchronously clears all 32 registers to 0. Outputs follow combinationally from the cleared state, so rd1=rd2=0 during reset.
- Register 0 reads as 0 at all times. Writes to register 0 from either write path are discarded.
- Reads are asynchronous. A register written at a rising edge shows its new value only after that edge; there is no write-to-read bypass within the same cycle.
- Instruction valid condition: opcode==0 and funct is in the supported set.
- Supported funct codes (A=rd1, B=rd2, sh=shamt):
  - 0x00 sll B<<sh; 0x02 srl B>>sh; 0x03 sra B>>>sh
  - 0x04 sllv B<<A[4:0]; 0x06 srlv; 0x07 srav
  - 0x20 add; 0x21 addu A+B; 0x22 sub; 0x23 subu A-B
  - 0x24 and; 0x25 or; 0x26 xor; 0x27 nor
  - 0x2A slt (signed, result 1/0); 0x2B sltu (unsigned)
- Arithmetic wraps modulo 2^32. Shift amounts use 5 bits only.
- Invalid instruction (opcode!=0 or unsupported funct): alu_result=0, zero=1, no writeback.
- Writeback at the rising edge, in priority order:
  1. If RW=1: reg[WR] <= WD. The instruction writeback is suppressed that cycle; the external port always wins.
  2. Else if the instruction is valid (and not an overflow-trapped add/sub): reg[rd] <= alu_result.
- Latency: result is combinational in the same cycle; it is committed at the next rising edge.
- Reset asserted mid-cycle overrides any pending write.

Optional Feature:
- Macro: MAIN_EXPERIMENT2_OVF_TRAP_EN.
- Defined:
  - ovf=1 when add (0x20) or sub (0x22) produces signed overflow; otherwise ovf=0.
  - When ovf=1, the instruction writeback is suppressed. alu_result still shows the wrapped sum/difference.
- Undefined:
  - ovf is tied to 0.
  - add/sub behave exactly like addu/subu and always write back.

Test Plan:
- Reset: hold rst_n=0, then release; Ins rs=1, rt=2 -> rd1=0, rd2=0. Ins=0x00000000 (sll $0,$0,0) -> alu_result=0, zero=1.
- Preload: RW=1, WR=1, WD=5 for one edge -> Ins with rs=1 reads rd1=5. Then RW=1, WR=0, WD=7 -> register 0 still reads 0.
- Shift and add, sequential edges with RW=0:
  - Ins=0x00011040 (sll $2,$1,1) -> $2=10.
  - Ins=0x00221820 (add $3,$1,$2) -> alu_result=15, $3=15.
- Sub and slt, sequential edges with RW=0:
  - Ins=0x00222022 (sub $4,$1,$2) -> $4=0xFFFFFFFB.
  - Ins=0x0081282A (slt $5,$4,$1) -> $5=1, zero=0.
  - Same operands with sltu -> alu_result=0.
- Priority/invalid:
  - RW=1, WR=9, WD=0x1234 while Ins=add with rd=8 -> $9=0x1234 and $8 unchanged.
  - Ins opcode=0x08 -> alu_result=0, no register changes.
- Overflow (macro defined): $6=0x7FFFFFFF, Ins add $7,$6,$6 -> ovf=1, alu_result=0xFFFFFFFE, $7 unchanged. With addu -> $7=0xFFFFFFFE, ovf=0.

Source files
------------

// File: rtl/main_experiment2.sv
// Single-cycle R-type slice: 32x32 register file, R-type ALU and writeback to rd.
// Define MAIN_EXPERIMENT2_OVF_TRAP_EN to flag and suppress writeback of overflowing add/sub.
module main_experiment2 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Ins,
  input  logic [4:0]  WR,
  input  logic [31:0] WD,
  input  logic        RW,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic        ovf
);

  localparam int unsigned NREGS = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;

`ifdef MAIN_EXPERIMENT2_OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [DW-1:0] regs [NREGS];

  logic [5:0]    opcode;
  logic [AW-1:0] rs, rt, rd, shamt;
  logic [5:0]    funct;

  assign opcode = Ins[31:26];
  assign rs     = Ins[25:21];
  assign rt     = Ins[20:16];
  assign rd     = Ins[15:11];
  assign shamt  = Ins[10:6];
  assign funct  = Ins[5:0];

  // Asynchronous reads; register 0 is hardwired to zero
  assign rd1 = (rs == '0) ? '0 : regs[rs];
  assign rd2 = (rt == '0) ? '0 : regs[rt];

  logic [DW-1:0] sum, diff;
  logic          valid, is_add, is_sub, raw_ovf, wb_en;

  assign sum  = rd1 + rd2;
  assign diff = rd1 - rd2;

  always_comb begin
    alu_result = '0;
    valid      = 1'b0;
    is_add     = 1'b0;
    is_sub     = 1'b0;
    if (opcode == '0) begin
      valid = 1'b1;
      case (funct)
        6'h00: alu_result = rd2 << shamt;
        6'h02: alu_result = rd2 >> shamt;
        6'h03: alu_result = DW'($signed(rd2) >>> shamt);
        6'h04: alu_result = rd2 << rd1[AW-1:0];
        6'h06: alu_result = rd2 >> rd1[AW-1:0];
        6'h07: alu_result = DW'($signed(rd2) >>> rd1[AW-1:0]);
        6'h20: begin alu_result = sum;  is_add = 1'b1; end
        6'h21: alu_result = sum;
        6'h22: begin alu_result = diff; is_sub = 1'b1; end
        6'h23: alu_result = diff;
        6'h24: alu_result = rd1 & rd2;
        6'h25: alu_result = rd1 | rd2;
        6'h26: alu_result = rd1 ^ rd2;
        6'h27: alu_result = ~(rd1 | rd2);
        6'h2A: alu_result = {{(DW-1){1'b0}}, $signed(rd1) < $signed(rd2)};
        6'h2B: alu_result = {{(DW-1){1'b0}}, rd1 < rd2};
        default: valid = 1'b0;
      endcase
    end
  end

  // Signed overflow: operands' signs (as seen by the operation) agree but result sign differs
  assign raw_ovf = (is_add & (rd1[DW-1] == rd2[DW-1]) & (sum[DW-1]  != rd1[DW-1])) |
                   (is_sub & (rd1[DW-1] != rd2[DW-1]) & (diff[DW-1] != rd1[DW-1]));
  assign ovf   = TRAP_EN & raw_ovf;
  assign zero  = (alu_result == '0);
  assign wb_en = valid & ~ovf;

  // External debug port has priority over instruction writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (RW) begin
      if (WR != '0) regs[WR] <= WD;
    end else if (wb_en && (rd != '0)) begin
      regs[rd] <= alu_result;
    end
  end

endmodule

// File: tb/tb_main_experiment2.sv
// Self-checking bench for main_experiment2 against a behavioural register/ALU model.
module tb_main_experiment2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] ins = '0;
  logic [4:0]  wr = '0;
  logic [31:0] wd = '0;
  logic        rw = 1'b0;
  logic [31:0] rd1, rd2, alu_result;
  logic        zero, ovf;

`ifdef MAIN_EXPERIMENT2_OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int checks = 0;
  int passes = 0;
  logic [31:0] mreg [32];

  main_experiment2 dut (
    .clk(clk), .rst_n(rst_n), .Ins(ins), .WR(wr), .WD(wd), .RW(rw),
    .rd1(rd1), .rd2(rd2), .alu_result(alu_result), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

  function automatic logic [31:0] mk(input int op, input int rs, input int rt,
                                     input int rd, input int sh, input int fn);
    return {6'(op), 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  // Reference model: what the instruction computes from the architectural registers
  function automatic void model_exec(input logic [31:0] i, output logic [31:0] res,
                                     output bit valid, output bit ov);
    logic [31:0] a, b, f;
    int unsigned sh, shv;
    longint full;
    a = mreg[i[25:21]];
    b = mreg[i[20:16]];
    f = 32'(i[5:0]);
    sh = int'(i[10:6]);
    shv = a % 32;
    res = 0; valid = 1'b1; ov = 1'b0;
    if (i[31:26] != 0) begin
      valid = 1'b0;
    end else if (f == 32'h00) res = b << sh;
    else if (f == 32'h02) res = b >> sh;
    else if (f == 32'h03) res = 32'($signed(b) >>> sh);
    else if (f == 32'h04) res = b << shv;
    else if (f == 32'h06) res = b >> shv;
    else if (f == 32'h07) res = 32'($signed(b) >>> shv);
    else if (f == 32'h20 || f == 32'h21) begin
      res = 32'(a + b);
      full = longint'($signed(a)) + longint'($signed(b));
      ov = TRAP && (f == 32'h20) && (full != longint'($signed(res)));
    end else if (f == 32'h22 || f == 32'h23) begin
      res = 32'(a - b);
      full = longint'($signed(a)) - longint'($signed(b));
      ov = TRAP && (f == 32'h22) && (full != longint'($signed(res)));
    end
    else if (f == 32'h24) res = a & b;
    else if (f == 32'h25) res = a | b;
    else if (f == 32'h26) res = a ^ b;
    else if (f == 32'h27) res = ~(a | b);
    else if (f == 32'h2A) res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    else if (f == 32'h2B) res = (a < b) ? 32'd1 : 32'd0;
    else valid = 1'b0;
  endfunction

  // One rising edge with the current inputs; model updated from pre-edge state
  task automatic commit();
    logic [31:0] res;
    bit valid, ov;
    model_exec(ins, res, valid, ov);
    @(posedge clk);
    #1;
    if (rw) begin
      if (wr != 0) mreg[wr] = wd;
    end else if (valid && !ov && ins[15:11] != 0) begin
      mreg[ins[15:11]] = res;
    end
  endtask

  task automatic set_read(input int rs, input int rt);
    ins = mk(0, rs, rt, 0, 0, 6'h3F);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    #3 rst_n = 1'b0;
    ins = mk(0, 1, 2, 0, 0, 6'h3F);
    repeat (2) @(posedge clk);
    #2;
    checks++; if (rd1 !== 32'd0) $display("FAIL reset_rd1 got %h exp %h", rd1, 32'd0); else passes++;
    checks++; if (rd2 !== 32'd0) $display("FAIL reset_rd2 got %h exp %h", rd2, 32'd0); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    ins = 32'h0000_0000;
    #1;
    checks++; if (alu_result !== 32'd0) $display("FAIL reset_sll_alu got %h exp %h", alu_result, 32'd0); else passes++;
    checks++; if (zero !== 1'b1) $display("FAIL reset_sll_zero got %b exp 1", zero); else passes++;
  endtask

  task automatic test_preload();
    rw = 1'b1; wr = 5'd1; wd = 32'd5;
    commit();
    rw = 1'b0;
    set_read(1, 0);
    checks++; if (rd1 !== 32'd5) $display("FAIL preload_r1 got %h exp %h", rd1, 32'd5); else passes++;
    rw = 1'b1; wr = 5'd0; wd = 32'd7;
    commit();
    rw = 1'b0;
    set_read(0, 0);
    checks++; if (rd1 !== 32'd0) $display("FAIL preload_r0_rd1 got %h exp %h", rd1, 32'd0); else passes++;
    checks++; if (rd2 !== 32'd0) $display("FAIL preload_r0_rd2 got %h exp %h", rd2, 32'd0); else passes++;
  endtask

  task automatic test_shift_add();
    ins = 32'h0001_1040; #1;
    checks++; if (alu_result !== 32'd10) $display("FAIL sll_alu got %h exp %h", alu_result, 32'd10); else passes++;
    commit();
    ins = 32'h0022_1820; #1;
    checks++; if (alu_result !== 32'd15) $display("FAIL add_alu got %h exp %h", alu_result, 32'd15); else passes++;
    commit();
    set_read(2, 3);
    checks++; if (rd1 !== 32'd10) $display("FAIL sll_wb got %h exp %h", rd1, 32'd10); else passes++;
    checks++; if (rd2 !== 32'd15) $display("FAIL add_wb got %h exp %h", rd2, 32'd15); else passes++;
  endtask

  task automatic test_sub_slt();
    ins = 32'h0022_2022; #1;
    checks++; if (alu_result !== 32'hFFFF_FFFB) $display("FAIL sub_alu got %h exp %h", alu_result, 32'hFFFF_FFFB); else passes++;
    commit();
    ins = 32'h0081_282A; #1;
    checks++; if (alu_result !== 32'd1) $display("FAIL slt_alu got %h exp %h", alu_result, 32'd1); else passes++;
    checks++; if (zero !== 1'b0) $display("FAIL slt_zero got %b exp 0", zero); else passes++;
    commit();
    set_read(4, 5);
    checks++; if (rd1 !== 32'hFFFF_FFFB) $display("FAIL sub_wb got %h exp %h", rd1, 32'hFFFF_FFFB); else passes++;
    checks++; if (rd2 !== 32'd1) $display("FAIL slt_wb got %h exp %h", rd2, 32'd1); else passes++;
    ins = 32'h0081_282B; #1;
    checks++; if (alu_result !== 32'd0) $display("FAIL sltu_alu got %h exp %h", alu_result, 32'd0); else passes++;
    checks++; if (zero !== 1'b1) $display("FAIL sltu_zero got %b exp 1", zero); else passes++;
    commit();
  endtask

  task automatic test_priority_invalid();
    rw = 1'b1; wr = 5'd9; wd = 32'h1234;
    ins = 32'h0022_4020;
    commit();
    rw = 1'b0;
    set_read(9, 8);
    checks++; if (rd1 !== 32'h1234) $display("FAIL prio_r9 got %h exp %h", rd1, 32'h1234); else passes++;
    checks++; if (rd2 !== 32'd0) $display("FAIL prio_r8 got %h exp %h", rd2, 32'd0); else passes++;
    ins = 32'h2022_4020; #1;
    checks++; if (alu_result !== 32'd0) $display("FAIL badop_alu got %h exp %h", alu_result, 32'd0); else passes++;
    checks++; if (zero !== 1'b1) $display("FAIL badop_zero got %b exp 1", zero); else passes++;
    commit();
    ins = mk(0, 1, 2, 8, 0, 6'h01); #1;
    checks++; if (alu_result !== 32'd0) $display("FAIL badfn_alu got %h exp %h", alu_result, 32'd0); else passes++;
    commit();
    for (int r = 0; r < 32; r++) begin
      set_read(r, 0);
      checks++; if (rd1 !== mreg[r]) $display("FAIL scan_r%0d got %h exp %h", r, rd1, mreg[r]); else passes++;
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp7;
    rw = 1'b1; wr = 5'd6; wd = 32'h7FFF_FFFF;
    commit();
    rw = 1'b0;
    ins = 32'h00C6_3820; #1;
    checks++; if (alu_result !== 32'hFFFF_FFFE) $display("FAIL ovf_add_alu got %h exp %h", alu_result, 32'hFFFF_FFFE); else passes++;
    checks++; if (ovf !== TRAP) $display("FAIL ovf_add_flag got %b exp %b", ovf, TRAP); else passes++;
    commit();
    exp7 = TRAP ? 32'd0 : 32'hFFFF_FFFE;
    set_read(7, 0);
    checks++; if (rd1 !== exp7) $display("FAIL ovf_add_wb got %h exp %h", rd1, exp7); else passes++;
    ins = 32'h00C6_3821; #1;
    checks++; if (ovf !== 1'b0) $display("FAIL ovf_addu_flag got %b exp 0", ovf); else passes++;
    commit();
    set_read(7, 0);
    checks++; if (rd1 !== 32'hFFFF_FFFE) $display("FAIL ovf_addu_wb got %h exp %h", rd1, 32'hFFFF_FFFE); else passes++;
  endtask

  task automatic test_random();
    logic [31:0] res;
    bit valid, ov;
    logic [5:0] fns [16];
    fns = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
            6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    for (int n = 0; n < 400; n++) begin
      rw = ($urandom_range(0, 3) == 0);
      wr = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0: wd = 32'h7FFF_FFFF;
        1: wd = 32'h8000_0000;
        default: wd = $urandom;
      endcase
      ins = mk(($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : 0,
               $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 31),
               ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : int'(fns[$urandom_range(0, 15)]));
      #1;
      model_exec(ins, res, valid, ov);
      checks++; if (rd1 !== mreg[ins[25:21]]) $display("FAIL rnd%0d_rd1 got %h exp %h", n, rd1, mreg[ins[25:21]]); else passes++;
      checks++; if (rd2 !== mreg[ins[20:16]]) $display("FAIL rnd%0d_rd2 got %h exp %h", n, rd2, mreg[ins[20:16]]); else passes++;
      checks++; if (alu_result !== res) $display("FAIL rnd%0d_alu ins %h got %h exp %h", n, ins, alu_result, res); else passes++;
      checks++; if (zero !== (res == 0)) $display("FAIL rnd%0d_zero got %b exp %b", n, zero, (res == 0)); else passes++;
      checks++; if (ovf !== ov) $display("FAIL rnd%0d_ovf ins %h got %b exp %b", n, ins, ovf, ov); else passes++;
      commit();
    end
    rw = 1'b0;
    for (int r = 0; r < 32; r++) begin
      set_read(0, r);
      checks++; if (rd2 !== mreg[r]) $display("FAIL rndscan_r%0d got %h exp %h", r, rd2, mreg[r]); else passes++;
    end
  endtask

  // Reset arriving before the edge must beat a pending external write
  task automatic test_reset_midcycle();
    @(negedge clk);
    rw = 1'b1; wr = 5'd3; wd = 32'hDEAD_BEEF;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    rw = 1'b0;
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    set_read(3, 1);
    checks++; if (rd1 !== 32'd0) $display("FAIL rstmid_r3 got %h exp %h", rd1, 32'd0); else passes++;
    checks++; if (rd2 !== 32'd0) $display("FAIL rstmid_r1 got %h exp %h", rd2, 32'd0); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    set_read(3, 0);
    checks++; if (rd1 !== 32'd0) $display("FAIL rstmid_after got %h exp %h", rd1, 32'd0); else passes++;
  endtask

  initial begin
    test_reset();
    test_preload();
    test_shift_add();
    test_sub_slt();
    test_priority_invalid();
    test_overflow();
    test_random();
    test_reset_midcycle();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
